// File: rtl/task3_circle_pkg.sv
// Shared types and screen constants for the circle-drawing VGA lab.
package task3_circle_pkg;

  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;
  localparam int unsigned X_W      = 8;
  localparam int unsigned Y_W      = 7;
  localparam int unsigned R_W      = 7;
  localparam int unsigned COLOUR_W = 3;
  localparam int unsigned COORD_W  = 10;
  localparam int unsigned CRIT_W   = 12;

  localparam logic [COLOUR_W-1:0] BLACK = 3'b000;

  typedef enum logic [1:0] {FILL, CIRCLE_INIT, CIRCLE, DONE} state_t;

endpackage

// File: rtl/circle_engine.sv
// Midpoint circle generator: one octant point per cycle, off-screen points masked.
module circle_engine
  import task3_circle_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [X_W-1:0]      cx,
  input  logic [Y_W-1:0]      cy,
  input  logic [R_W-1:0]      radius,
  input  logic [COLOUR_W-1:0] colour,
  output logic [X_W-1:0]      x_c,
  output logic [Y_W-1:0]      y_c,
  output logic [COLOUR_W-1:0] colour_c,
  output logic                plot_c,
  output logic                done_c
);

  logic signed [COORD_W-1:0] ox, oy, ox_n, oy_n, dx, dy, px, py;
  logic signed [CRIT_W-1:0]  crit, crit_n;
  logic [2:0]                oct;
  logic                      active;
  logic                      on_screen;

  // Octant point selection and screen clipping
  always_comb begin
    dx = '0;
    dy = '0;
    case (oct)
      3'd0: begin dx = ox;  dy = oy;  end
      3'd1: begin dx = oy;  dy = ox;  end
      3'd2: begin dx = -ox; dy = oy;  end
      3'd3: begin dx = -oy; dy = ox;  end
      3'd4: begin dx = -ox; dy = -oy; end
      3'd5: begin dx = -oy; dy = -ox; end
      3'd6: begin dx = ox;  dy = -oy; end
      3'd7: begin dx = oy;  dy = -ox; end
      default: ;
    endcase
    px = $signed(COORD_W'(cx)) + dx;
    py = $signed(COORD_W'(cy)) + dy;
    on_screen = !px[COORD_W-1] && (px < $signed(COORD_W'(SCREEN_W))) &&
                !py[COORD_W-1] && (py < $signed(COORD_W'(SCREEN_H)));
  end

  // Iteration update applied after the eighth octant point
  always_comb begin
    oy_n = oy + COORD_W'(1);
    ox_n = ox;
    if (crit[CRIT_W-1] || crit == '0) begin
      crit_n = crit + (CRIT_W'(oy_n) <<< 1) + CRIT_W'(1);
    end else begin
      ox_n   = ox - COORD_W'(1);
      crit_n = crit + ((CRIT_W'(oy_n) - CRIT_W'(ox_n)) <<< 1) + CRIT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active <= 1'b0;
      oct    <= '0;
      ox     <= '0;
      oy     <= '0;
      crit   <= '0;
    end else if (start) begin
      active <= 1'b1;
      oct    <= '0;
      ox     <= COORD_W'(radius);
      oy     <= '0;
      crit   <= CRIT_W'(1) - CRIT_W'(radius);
    end else if (active) begin
      oct <= oct + 3'd1;
      if (oct == 3'd7) begin
        ox     <= ox_n;
        oy     <= oy_n;
        crit   <= crit_n;
        active <= (oy_n <= ox_n);
      end
    end
  end

  assign x_c      = px[X_W-1:0];
  assign y_c      = py[Y_W-1:0];
  assign colour_c = colour;
  assign plot_c   = active && on_screen;
  assign done_c   = !active;

endmodule

// File: rtl/vga_adapter.sv
// Minimal 160x120 framebuffer with 640x480 scan-out, each stored pixel shown as a 4x4 block.
module vga_adapter
  import task3_circle_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [COLOUR_W-1:0] colour,
  input  logic [X_W-1:0]      x,
  input  logic [Y_W-1:0]      y,
  input  logic                plot,
  output logic [7:0]          vga_r,
  output logic [7:0]          vga_g,
  output logic [7:0]          vga_b,
  output logic                vga_hs,
  output logic                vga_vs,
  output logic                vga_clk
);

  localparam int unsigned H_TOTAL  = 800;
  localparam int unsigned H_VIS    = 640;
  localparam int unsigned H_SYNC_S = 656;
  localparam int unsigned H_SYNC_E = 752;
  localparam int unsigned V_TOTAL  = 525;
  localparam int unsigned V_VIS    = 480;
  localparam int unsigned V_SYNC_S = 490;
  localparam int unsigned V_SYNC_E = 492;
  localparam int unsigned ADDR_W   = 15;
  localparam int unsigned FB_DEPTH = SCREEN_W * SCREEN_H;

  logic [COLOUR_W-1:0] fb [FB_DEPTH];
  logic [COLOUR_W-1:0] rd_data;
  logic [9:0]          hcnt, vcnt;
  logic [ADDR_W-1:0]   wr_addr, rd_addr;
  logic                visible, visible_q, wr_en;

  assign visible = (hcnt < 10'(H_VIS)) && (vcnt < 10'(V_VIS));
  assign wr_en   = plot && (x < X_W'(SCREEN_W)) && (y < Y_W'(SCREEN_H));
  assign wr_addr = ADDR_W'(y) * ADDR_W'(SCREEN_W) + ADDR_W'(x);
  assign rd_addr = visible ? ADDR_W'(vcnt[9:2]) * ADDR_W'(SCREEN_W) + ADDR_W'(hcnt[9:2]) : '0;

  always_ff @(posedge clk) begin
    if (wr_en) fb[wr_addr] <= colour;
    rd_data <= fb[rd_addr];
  end

  // Pixel clock is clk/2; scan counters advance once per pixel clock
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vga_clk   <= 1'b0;
      hcnt      <= '0;
      vcnt      <= '0;
      visible_q <= 1'b0;
      vga_hs    <= 1'b1;
      vga_vs    <= 1'b1;
    end else begin
      vga_clk   <= ~vga_clk;
      visible_q <= visible;
      vga_hs    <= !((hcnt >= 10'(H_SYNC_S)) && (hcnt < 10'(H_SYNC_E)));
      vga_vs    <= !((vcnt >= 10'(V_SYNC_S)) && (vcnt < 10'(V_SYNC_E)));
      if (vga_clk) begin
        if (hcnt == 10'(H_TOTAL - 1)) begin
          hcnt <= '0;
          vcnt <= (vcnt == 10'(V_TOTAL - 1)) ? '0 : vcnt + 10'd1;
        end else begin
          hcnt <= hcnt + 10'd1;
        end
      end
    end
  end

  assign vga_r = {8{visible_q & rd_data[2]}};
  assign vga_g = {8{visible_q & rd_data[1]}};
  assign vga_b = {8{visible_q & rd_data[0]}};

endmodule

// File: rtl/task3_circle_top.sv
// Board top: clears the framebuffer to black, draws one circle outline, then idles with done lit.
module task3_circle_top
  import task3_circle_pkg::*;
#(
  parameter int unsigned         CENTRE_X = 80,
  parameter int unsigned         CENTRE_Y = 60,
  parameter int unsigned         RADIUS   = 40,
  parameter logic [COLOUR_W-1:0] COLOUR   = 3'b010
) (
  input  logic                CLOCK_50,
  input  logic [3:0]          KEY,
  input  logic [9:0]          SW,
  output logic [9:0]          LEDR,
  output logic [6:0]          HEX0,
  output logic [6:0]          HEX1,
  output logic [6:0]          HEX2,
  output logic [6:0]          HEX3,
  output logic [6:0]          HEX4,
  output logic [6:0]          HEX5,
  output logic [7:0]          VGA_R,
  output logic [7:0]          VGA_G,
  output logic [7:0]          VGA_B,
  output logic                VGA_HS,
  output logic                VGA_VS,
  output logic                VGA_CLK,
  output logic [X_W-1:0]      VGA_X,
  output logic [Y_W-1:0]      VGA_Y,
  output logic [COLOUR_W-1:0] VGA_COLOUR,
  output logic                VGA_PLOT
);

  logic                clk, rst, unused_inputs;
  state_t              state, state_n;
  logic [X_W-1:0]      fill_x, x_c, eng_x;
  logic [Y_W-1:0]      fill_y, y_c, eng_y;
  logic [COLOUR_W-1:0] colour_c, eng_colour;
  logic                fill_last, start_c, plot_c, done_c, eng_plot, eng_done, done;

  assign clk           = CLOCK_50;
  assign rst           = KEY[3];
  assign unused_inputs = ^{KEY[2:0], SW};
  assign fill_last     = (fill_x == X_W'(SCREEN_W - 1)) && (fill_y == Y_W'(SCREEN_H - 1));

  circle_engine u_engine (
    .clk      (clk),
    .rst      (rst),
    .start    (start_c),
    .cx       (X_W'(CENTRE_X)),
    .cy       (Y_W'(CENTRE_Y)),
    .radius   (R_W'(RADIUS)),
    .colour   (COLOUR),
    .x_c      (eng_x),
    .y_c      (eng_y),
    .colour_c (eng_colour),
    .plot_c   (eng_plot),
    .done_c   (eng_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FILL;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      FILL:        if (fill_last) state_n = CIRCLE_INIT;
      CIRCLE_INIT: state_n = CIRCLE;
      CIRCLE:      if (eng_done) state_n = DONE;
      DONE:        state_n = DONE;
      default:     state_n = FILL;
    endcase
  end

  always_comb begin
    start_c  = 1'b0;
    x_c      = '0;
    y_c      = '0;
    colour_c = BLACK;
    plot_c   = 1'b0;
    done_c   = 1'b0;
    case (state)
      FILL: begin
        x_c    = fill_x;
        y_c    = fill_y;
        plot_c = 1'b1;
      end
      CIRCLE_INIT: start_c = 1'b1;
      CIRCLE: begin
        x_c      = eng_x;
        y_c      = eng_y;
        colour_c = eng_colour;
        plot_c   = eng_plot;
      end
      DONE:    done_c = 1'b1;
      default: ;
    endcase
  end

  // Column-major fill scan: y inner, x outer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_x <= '0;
      fill_y <= '0;
    end else if (state == FILL) begin
      if (fill_y == Y_W'(SCREEN_H - 1)) begin
        fill_y <= '0;
        fill_x <= fill_x + X_W'(1);
      end else begin
        fill_y <= fill_y + Y_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      VGA_X      <= '0;
      VGA_Y      <= '0;
      VGA_COLOUR <= '0;
      VGA_PLOT   <= 1'b0;
      done       <= 1'b0;
    end else begin
      VGA_X      <= x_c;
      VGA_Y      <= y_c;
      VGA_COLOUR <= colour_c;
      VGA_PLOT   <= plot_c;
      done       <= done_c;
    end
  end

  vga_adapter u_vga (
    .clk     (clk),
    .rst     (rst),
    .colour  (VGA_COLOUR),
    .x       (VGA_X),
    .y       (VGA_Y),
    .plot    (VGA_PLOT),
    .vga_r   (VGA_R),
    .vga_g   (VGA_G),
    .vga_b   (VGA_B),
    .vga_hs  (VGA_HS),
    .vga_vs  (VGA_VS),
    .vga_clk (VGA_CLK)
  );

  assign LEDR = {9'd0, done};
  assign HEX0 = 7'h7F;
  assign HEX1 = 7'h7F;
  assign HEX2 = 7'h7F;
  assign HEX3 = 7'h7F;
  assign HEX4 = 7'h7F;
  assign HEX5 = 7'h7F;

endmodule

// File: tb/tb_task3_circle_top.sv
// Bench for task3_circle_top: default circle instance plus an off-screen-clipping instance.
module tb_task3_circle_top;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic [3:0] key_a = 4'b1000;
  logic [3:0] key_b = 4'b1000;
  logic [9:0] sw = '0;

  logic [9:0] ledr_a, ledr_b;
  logic [6:0] hex_a [6];
  logic [6:0] hex_b [6];
  logic [7:0] unused_r_a, unused_g_a, unused_b_a, unused_r_b, unused_g_b, unused_b_b;
  logic       unused_hs_a, unused_vs_a, unused_clk_a, unused_hs_b, unused_vs_b, unused_clk_b;
  logic [7:0] x_a, x_b;
  logic [6:0] y_a, y_b;
  logic [2:0] col_a, col_b;
  logic       plot_a, plot_b;

  task3_circle_top dut_a (
    .CLOCK_50(clk), .KEY(key_a), .SW(sw), .LEDR(ledr_a),
    .HEX0(hex_a[0]), .HEX1(hex_a[1]), .HEX2(hex_a[2]), .HEX3(hex_a[3]), .HEX4(hex_a[4]), .HEX5(hex_a[5]),
    .VGA_R(unused_r_a), .VGA_G(unused_g_a), .VGA_B(unused_b_a),
    .VGA_HS(unused_hs_a), .VGA_VS(unused_vs_a), .VGA_CLK(unused_clk_a),
    .VGA_X(x_a), .VGA_Y(y_a), .VGA_COLOUR(col_a), .VGA_PLOT(plot_a)
  );

  task3_circle_top #(.CENTRE_X(5), .CENTRE_Y(5), .RADIUS(20)) dut_b (
    .CLOCK_50(clk), .KEY(key_b), .SW(sw), .LEDR(ledr_b),
    .HEX0(hex_b[0]), .HEX1(hex_b[1]), .HEX2(hex_b[2]), .HEX3(hex_b[3]), .HEX4(hex_b[4]), .HEX5(hex_b[5]),
    .VGA_R(unused_r_b), .VGA_G(unused_g_b), .VGA_B(unused_b_b),
    .VGA_HS(unused_hs_b), .VGA_VS(unused_vs_b), .VGA_CLK(unused_clk_b),
    .VGA_X(x_b), .VGA_Y(y_b), .VGA_COLOUR(col_b), .VGA_PLOT(plot_b)
  );

  // Selected-instance view used by the scenario tasks
  logic       sel = 1'b0;
  logic [7:0] s_x;
  logic [6:0] s_y;
  logic [2:0] s_col;
  logic       s_plot;
  logic [9:0] s_ledr;
  assign s_x    = sel ? x_b    : x_a;
  assign s_y    = sel ? y_b    : y_a;
  assign s_col  = sel ? col_b  : col_a;
  assign s_plot = sel ? plot_b : plot_a;
  assign s_ledr = sel ? ledr_b : ledr_a;

  int total = 0;
  int bad   = 0;
  int static_err = 0;
  int range_err  = 0;

  // Continuous watch on fixed outputs and on plotted coordinate range
  always @(negedge clk) begin
    for (int i = 0; i < 6; i++)
      if (hex_a[i] !== 7'h7F || hex_b[i] !== 7'h7F) static_err++;
    if (ledr_a[9:1] !== 9'd0 || ledr_b[9:1] !== 9'd0) static_err++;
    if (plot_a === 1'b1 && (x_a > 8'd159 || y_a > 7'd119)) range_err++;
    if (plot_b === 1'b1 && (x_b > 8'd159 || y_b > 7'd119)) range_err++;
  end

  typedef struct { int x; int y; } pt_t;
  pt_t exp_q[$];
  int  cx, cy, r;

  // Reference: visible circle points in emission order, from integer midpoint rules
  task automatic build_expected();
    int ox, oy, crit, px, py;
    int dxs[8];
    int dys[8];
    exp_q.delete();
    ox = r; oy = 0; crit = 1 - r;
    while (oy <= ox) begin
      dxs = '{ox, oy, -ox, -oy, -ox, -oy, ox, oy};
      dys = '{oy, ox, oy, ox, -oy, -ox, -oy, -ox};
      for (int k = 0; k < 8; k++) begin
        px = cx + dxs[k];
        py = cy + dys[k];
        if (px >= 0 && px < 160 && py >= 0 && py < 120) exp_q.push_back('{px, py});
      end
      oy++;
      if (crit <= 0) crit += 2 * oy + 1;
      else begin
        ox--;
        crit += 2 * (oy - ox) + 1;
      end
    end
  endtask

  task automatic select(input bit which);
    sel = which;
    if (which) begin cx = 5;  cy = 5;  r = 20; end
    else       begin cx = 80; cy = 60; r = 40; end
    build_expected();
  endtask

  task automatic set_rst(input bit v);
    if (sel) key_b[3] = v;
    else     key_a[3] = v;
  endtask

  task automatic test_reset();
    set_rst(1'b1);
    repeat ($urandom_range(2, 5)) @(negedge clk);
    total++;
    if ({s_x, s_y, s_col, s_plot, s_ledr[0]} !== 20'd0) begin
      bad++;
      $display("FAIL reset_outputs: got x=%0d y=%0d c=%0d plot=%b done=%b, want all 0",
               s_x, s_y, s_col, s_plot, s_ledr[0]);
    end
    set_rst(1'b0);
  endtask

  task automatic test_fill();
    int errs = 0;
    int first_bad = -1;
    for (int i = 0; i < 19200; i++) begin
      @(negedge clk);
      if (i == 0) begin
        total++;
        if ({s_x, s_y, s_col, s_plot} !== {8'd0, 7'd0, 3'd0, 1'b1}) begin
          bad++;
          $display("FAIL fill_first: got (%0d,%0d) c=%0d plot=%b, want (0,0) c=0 plot=1",
                   s_x, s_y, s_col, s_plot);
        end
      end
      if (s_x !== 8'(i / 120) || s_y !== 7'(i % 120) || s_col !== 3'd0 || s_plot !== 1'b1) begin
        if (errs == 0) first_bad = i;
        errs++;
      end
      if (i == 19199) begin
        total++;
        if ({s_x, s_y, s_col, s_plot} !== {8'd159, 7'd119, 3'd0, 1'b1}) begin
          bad++;
          $display("FAIL fill_last: got (%0d,%0d) c=%0d plot=%b, want (159,119) c=0 plot=1",
                   s_x, s_y, s_col, s_plot);
        end
      end
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL fill_sequence: %0d wrong pixels (first at index %0d), want 0", errs, first_bad);
    end
  endtask

  task automatic test_circle();
    pt_t obs[$];
    int  cyc = 19200;
    bit  got_done = 1'b0;
    int  col_err = 0, ord_err = 0, dist_err = 0, n, dx, dy, e;
    pt_t targets[4];
    @(negedge clk);
    cyc++;
    total++;
    if (s_plot !== 1'b0) begin
      bad++;
      $display("FAIL circle_init_plot: got plot=%b, want 0", s_plot);
    end
    while (!got_done && cyc < 19500) begin
      @(negedge clk);
      cyc++;
      if (s_plot === 1'b1) begin
        obs.push_back('{int'(s_x), int'(s_y)});
        if (s_col !== 3'b010) col_err++;
      end
      if (s_ledr[0] === 1'b1) got_done = 1'b1;
    end
    total++;
    if (!got_done) begin
      bad++;
      $display("FAIL done_latency: done not seen after %0d cycles, want < 19500", cyc);
    end
    total++;
    if (obs.size() != exp_q.size()) begin
      bad++;
      $display("FAIL circle_count: got %0d plotted points, want %0d", obs.size(), exp_q.size());
    end
    n = (obs.size() < exp_q.size()) ? obs.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      if (obs[i].x != exp_q[i].x || obs[i].y != exp_q[i].y) ord_err++;
    total++;
    if (ord_err != 0) begin
      bad++;
      $display("FAIL circle_points: %0d points differ from reference, want 0", ord_err);
    end
    total++;
    if (col_err != 0) begin
      bad++;
      $display("FAIL circle_colour: %0d plots not colour 2, want 0", col_err);
    end
    if (sel == 1'b0) begin
      foreach (obs[i]) begin
        dx = obs[i].x - cx;
        dy = obs[i].y - cy;
        e  = dx * dx + dy * dy - r * r;
        if (e > 40 || e < -40) dist_err++;
      end
      total++;
      if (dist_err != 0) begin
        bad++;
        $display("FAIL circle_radius: %0d points off radius by >40, want 0", dist_err);
      end
      targets = '{'{120, 60}, '{40, 60}, '{80, 100}, '{80, 20}};
      foreach (targets[t]) begin
        bit found = 1'b0;
        foreach (obs[i]) if (obs[i].x == targets[t].x && obs[i].y == targets[t].y) found = 1'b1;
        total++;
        if (!found) begin
          bad++;
          $display("FAIL circle_key_point: (%0d,%0d) plotted=0, want 1", targets[t].x, targets[t].y);
        end
      end
    end
  endtask

  task automatic test_idle();
    int plots = 0, undone = 0;
    repeat (5000) begin
      @(negedge clk);
      if (s_plot !== 1'b0) plots++;
      if (s_ledr[0] !== 1'b1) undone++;
    end
    total++;
    if (plots != 0) begin
      bad++;
      $display("FAIL idle_plot: got %0d plot cycles in DONE, want 0", plots);
    end
    total++;
    if (undone != 0) begin
      bad++;
      $display("FAIL idle_done: done low on %0d cycles, want 0", undone);
    end
  endtask

  task automatic test_reset_mid_circle();
    set_rst(1'b1);
    @(negedge clk);
    set_rst(1'b0);
    repeat (19201 + $urandom_range(1, 150)) @(negedge clk);
    total++;
    if (s_ledr[0] !== 1'b0) begin
      bad++;
      $display("FAIL mid_not_done: got done=%b before reset, want 0", s_ledr[0]);
    end
    #($urandom_range(1, 8));
    set_rst(1'b1);
    #1;
    total++;
    if ({s_x, s_y, s_col, s_plot, s_ledr[0]} !== 20'd0) begin
      bad++;
      $display("FAIL mid_reset_outputs: got x=%0d y=%0d c=%0d plot=%b done=%b, want all 0",
               s_x, s_y, s_col, s_plot, s_ledr[0]);
    end
    repeat ($urandom_range(1, 4)) @(negedge clk);
    set_rst(1'b0);
    test_fill();
    test_circle();
  endtask

  task automatic test_static();
    total++;
    if (static_err != 0) begin
      bad++;
      $display("FAIL hex_ledr_static: %0d violations, want 0", static_err);
    end
    total++;
    if (range_err != 0) begin
      bad++;
      $display("FAIL plot_range: %0d out-of-range plots, want 0", range_err);
    end
  endtask

  initial begin
    select(1'b0);
    test_reset();
    test_fill();
    test_circle();
    test_idle();
    test_reset_mid_circle();
    select(1'b1);
    test_reset();
    test_fill();
    test_circle();
    test_static();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
